// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter.
//   cnt_mode_e : boundary behaviour (wrap around or saturate)
//   cnt_dir_e  : count direction
package counter_pkg;

  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP  = 1'b1} cnt_dir_e;

endpackage

// File: rtl/counter_if.sv
// Signal bundle for driving/observing updown_mod_counter from a bench.
// Base counter signals (clk, rst_n, load_n, ce, up_down, data_load,
// count_out, max_count, zero) plus the modulo/saturation extensions
// (sat_mode, step, limit, clr_ovf, bound_evt, ovf_sticky).
interface counter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input logic clk
);
  logic              rst_n;
  logic              load_n;
  logic              ce;
  logic              up_down;
  logic [WIDTH-1:0]  data_load;
  logic [WIDTH-1:0]  count_out;
  logic              max_count;
  logic              zero;
  logic              sat_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              clr_ovf;
  logic              bound_evt;
  logic              ovf_sticky;
endinterface

// File: rtl/counter_next_calc.sv
// Combinational next-count calculator for one enabled count cycle.
//   count : current registered count (may exceed limit if limit dropped)
//   s     : effective step, already clamped to <= limit
//   limit : terminal value, legal range 0..limit
//   dir   : CNT_UP / CNT_DOWN
//   mode  : CNT_WRAP / CNT_SAT
//   nxt   : next count value
//   evt   : boundary event (wrap, saturation, or out-of-range recovery)
import counter_pkg::*;

module counter_next_calc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] limit,
  input  cnt_dir_e         dir,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] nxt,
  output logic             evt
);

  // One extra bit so count+s and limit+1 never truncate.
  logic [WIDTH:0] c, sx, lim, lim1, sum;

  assign c    = {1'b0, count};
  assign sx   = {1'b0, s};
  assign lim  = {1'b0, limit};
  assign lim1 = lim + 1'b1;
  assign sum  = c + sx;

  always_comb begin
    nxt = count;
    evt = 1'b0;
    if (c > lim) begin
      // limit was lowered under us: snap back into range regardless of dir
      nxt = (mode == CNT_SAT) ? limit : '0;
      evt = 1'b1;
    end else if (s == '0) begin
      nxt = count;
    end else if (dir == CNT_UP) begin
      if (sum > lim) begin
        evt = 1'b1;
        nxt = (mode == CNT_SAT) ? limit : WIDTH'(sum - lim1);
      end else begin
        nxt = WIDTH'(sum);
      end
    end else begin
      if (c < sx) begin
        evt = 1'b1;
        nxt = (mode == CNT_SAT) ? '0 : WIDTH'(c + lim1 - sx);
      end else begin
        nxt = WIDTH'(c - sx);
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with runtime modulus (0..limit), variable step,
// wrap or saturate at boundaries, and boundary event/sticky flags.
//   clk, rst_n  : clock, async active-low reset
//   load_n      : sync load (active low), beats ce
//   ce          : count enable
//   up_down     : 1 up, 0 down
//   sat_mode    : 0 wrap, 1 saturate
//   step        : per-cycle amount (clamped to limit)
//   limit       : terminal count value
//   data_load   : load value (clamped to limit)
//   clr_ovf     : clears ovf_sticky (a same-cycle event wins)
//   count_out   : registered count
//   max_count   : count_out == limit (combinational)
//   zero        : count_out == 0 (combinational)
//   bound_evt   : one-cycle registered event pulse
//   ovf_sticky  : sticky event flag
import counter_pkg::*;

module updown_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic              ce,
  input  logic              up_down,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              bound_evt,
  output logic              ovf_sticky
);

  logic [WIDTH-1:0] step_w, s, calc_nxt, cnt_d;
  logic             calc_evt, evt_d, ld_clamp;
  cnt_mode_e        mode;
  cnt_dir_e         dir;

  assign mode     = cnt_mode_e'(sat_mode);
  assign dir      = cnt_dir_e'(up_down);
  assign step_w   = WIDTH'(step);
  assign s        = (step_w < limit) ? step_w : limit;
  assign ld_clamp = data_load > limit;

  counter_next_calc #(.WIDTH(WIDTH)) u_calc (
    .count (count_out),
    .s     (s),
    .limit (limit),
    .dir   (dir),
    .mode  (mode),
    .nxt   (calc_nxt),
    .evt   (calc_evt)
  );

  always_comb begin
    cnt_d = count_out;
    evt_d = 1'b0;
    if (!load_n) begin
      cnt_d = ld_clamp ? limit : data_load;
      evt_d = ld_clamp;
    end else if (ce) begin
      cnt_d = calc_nxt;
      evt_d = calc_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out  <= '0;
      bound_evt  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count_out  <= cnt_d;
      bound_evt  <= evt_d;
      ovf_sticky <= evt_d | (ovf_sticky & ~clr_ovf);
    end
  end

  assign max_count = (count_out == limit);
  assign zero      = (count_out == '0);

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and limit width in bits (>=2).
REQ-002 Parameter STEP_W, default 2, step input width in bits (1..WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 load_n  input  1  active-low synchronous load strobe.
REQ-006 ce  input  1  count enable.
REQ-007 up_down  input  1  direction; 1 = up, 0 = down.
REQ-008 sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
REQ-009 step  input  STEP_W  increment/decrement amount per enabled cycle.
REQ-010 limit  input  WIDTH  runtime terminal value; legal count range is 0..limit.
REQ-011 data_load  input  WIDTH  load value.
REQ-012 clr_ovf  input  1  clears sticky overflow flag.
REQ-013 count_out  output  WIDTH  registered count.
REQ-014 max_count  output  1  count_out == limit.
REQ-015 zero  output  1  count_out == 0.
REQ-016 bound_evt  output  1  registered one-cycle pulse on wrap or saturation event.
REQ-017 ovf_sticky  output  1  registered sticky flag, set on any boundary event.

Function
REQ-018 Priority per cycle: load (load_n=0) > count (ce=1) > hold; ce ignored while loading.
REQ-019 Load: count_out <= min(data_load, limit) next cycle; bound_evt pulses only if data_load > limit (clamp).
REQ-020 Effective step s = min(step, limit); s=0 holds count, no event.
REQ-021 Arithmetic in WIDTH+1 bits; no intermediate truncation.
REQ-022 Up, count+s <= limit: count_out <= count+s, no event.
REQ-023 Up, count+s > limit: wrap -> count+s-(limit+1); sat -> limit; bound_evt next cycle.
REQ-024 Down, count >= s: count_out <= count-s, no event.
REQ-025 Down, count < s: wrap -> count+(limit+1)-s; sat -> 0; bound_evt next cycle.
REQ-026 Saturated hold (sat, at limit going up or at 0 going down, s>0): count unchanged, bound_evt still pulses each enabled cycle.
REQ-027 Limit lowered below count_out: next ce cycle forces count_out to 0 (wrap) or limit (sat), either direction, with bound_evt; without ce, count holds out of range.
REQ-028 limit=0: count forced/held at 0, max_count=zero=1.
REQ-029 max_count, zero: combinational decode of count_out and current limit, no extra latency.
REQ-030 ovf_sticky: set on bound_evt cycle condition; cleared by clr_ovf; simultaneous set and clear -> set wins.
REQ-031 bound_evt deasserts next cycle unless a new event occurs; back-to-back events keep it high.

Reset
REQ-032 rst_n low asynchronously forces count_out=0, bound_evt=0, ovf_sticky=0; zero=1, max_count=(limit==0).
REQ-033 Reset mid-count or mid-load abandons the operation; first update after release follows REQ-018 on that edge's inputs.

Structure
REQ-034 Shared package counter_pkg holds typedef enum cnt_mode_e {CNT_WRAP, CNT_SAT} and typedef enum cnt_dir_e {CNT_DOWN, CNT_UP}; sat_mode/up_down cast to these internally.
REQ-035 One combinational sub-module counter_next_calc computes next count and event flag from count, s, limit, direction, mode; top holds registers and flag logic.
REQ-036 Interface bundle for the bench extends the existing counter interface with sat_mode, step, limit, clr_ovf, bound_evt, ovf_sticky.

Verification (WIDTH=4, STEP_W=2)
REQ-037 limit=9, wrap, up, step=3 from 0, ce=1 x4 -> 3,6,9,2; bound_evt high only after 4th edge; max_count high at 9.
REQ-038 limit=9, sat, down, step=2, load 3 then ce x3 -> 3,1,0,0; bound_evt on 3rd and 4th enabled cycles; ovf_sticky=1.
REQ-039 limit=7, load_n=0 with data_load=12 and ce=1 -> count_out=7, bound_evt pulse, max_count=1.
REQ-040 count=12, limit=15, then limit changed to 5, wrap, up, ce=1 -> count_out=0, bound_evt=1; next cycle count 1 (step=1).
REQ-041 ovf_sticky=1, clr_ovf=1 with concurrent wrap event -> ovf_sticky stays 1; next cycle clr_ovf=1, no event -> 0.
REQ-042 rst_n pulsed low mid-cycle at count=6 -> count_out=0, flags 0 immediately, before next clk edge.
